// File: rtl/parity_frame_tx_if.sv
// Handshake and serial-line bundle between an upstream parity encoder and the frame transmitter.
interface parity_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  parity_in;
  logic                  in_valid;
  logic                  in_ready;
  logic                  tx_out;
  logic                  busy;
  logic                  frame_done;
  logic                  parity_err;

  modport master (
    output data_in, parity_in, in_valid,
    input  in_ready, tx_out, busy, frame_done, parity_err
  );

  modport slave (
    input  data_in, parity_in, in_valid,
    output in_ready, tx_out, busy, frame_done, parity_err
  );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial framer: start, DATA_WIDTH data bits LSB first, supplied parity bit, stop; re-checks parity at accept.
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (low)
// DATA   | data bits, shift register LSB on the line
// PARITY | latched parity bit as supplied
// STOP   | stop bit (high), frame_done follows
module parity_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic              clk,
  input logic              rst,
  parity_frame_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      bit_idx, bit_idx_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic                  par_q, par_n;
  logic                  tx_q, tx_n;
  logic                  done_q, done_n;
  logic                  perr_q, perr_n;
  logic                  cnt_last;

  assign cnt_last       = (cnt == CNT_LAST);
  assign bus.in_ready   = (state == IDLE) && !rst;
  assign bus.busy       = (state != IDLE);
  assign bus.tx_out     = tx_q;
  assign bus.frame_done = done_q;
  assign bus.parity_err = perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      par_q     <= par_n;
      tx_q      <= tx_n;
      done_q    <= done_n;
      perr_q    <= perr_n;
    end
  end

  // tx_n is the line value for the cycle after this edge, so the line is a pure register.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    par_n     = par_q;
    tx_n      = 1'b1;
    done_n    = 1'b0;
    perr_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          state_n = START;
          cnt_n   = '0;
          shift_n = bus.data_in;
          par_n   = bus.parity_in;
          perr_n  = (bus.parity_in != ~^bus.data_in);
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (cnt_last) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = shift_reg[0];
        end else begin
          cnt_n = cnt + 1'b1;
          tx_n  = 1'b0;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n   = '0;
          shift_n = shift_reg >> 1;
          if (bit_idx == IDX_LAST) begin
            state_n = PARITY;
            tx_n    = par_q;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shift_n[0];
          end
        end else begin
          cnt_n = cnt + 1'b1;
          tx_n  = shift_reg[0];
        end
      end
      PARITY: begin
        if (cnt_last) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          tx_n  = par_q;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (cnt_last) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Randomized self-checking bench for parity_frame_tx against a per-cycle line model built from the frame format.
module tb_parity_frame_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FL  = (DW + 3) * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_frame_tx_if #(.DATA_WIDTH(DW)) bus ();

  parity_frame_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic r_tx   [0:99];
  logic r_busy [0:99];
  logic r_done [0:99];
  logic r_perr [0:99];
  logic r_rdy  [0:99];

  // Expected line level idx cycles after the accept edge (idx 0 = first START cycle).
  function automatic logic exp_line(input logic [DW-1:0] d, input logic p, input int idx);
    int slot;
    slot = idx / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return d[slot-1];
    if (slot == DW + 1) return p;
    return 1'b1;
  endfunction

  task automatic launch(input logic [DW-1:0] d, input logic p);
    @(negedge clk);
    bus.data_in   = d;
    bus.parity_in = p;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r_tx[i]   = bus.tx_out;
      r_busy[i] = bus.busy;
      r_done[i] = bus.frame_done;
      r_perr[i] = bus.parity_err;
      r_rdy[i]  = bus.in_ready;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d ready=%b tx=%b busy=%b, want ready=0 tx=1 busy=0",
                 i, bus.in_ready, bus.tx_out, bus.busy);
      end
    end
    rst = 1'b0;
    capture(20);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (r_tx[i] !== 1'b1 || r_rdy[i] !== 1'b1 || r_busy[i] !== 1'b0 ||
          r_done[i] !== 1'b0 || r_perr[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d tx=%b ready=%b busy=%b done=%b perr=%b, want 1 1 0 0 0",
                 i, r_tx[i], r_rdy[i], r_busy[i], r_done[i], r_perr[i]);
      end
    end
  endtask

  task automatic test_single_frame;
    launch(8'hA5, 1'b1);
    capture(FL + 2);
    for (int i = 0; i < FL + 2; i++) begin
      checks++;
      if (r_tx[i] !== exp_line(8'hA5, 1'b1, i) || r_busy[i] !== (i < FL) ||
          r_done[i] !== (i == FL) || r_perr[i] !== 1'b0 || r_rdy[i] !== (i >= FL)) begin
        errors++;
        $display("FAIL single_frame cyc=%0d tx=%b busy=%b done=%b perr=%b ready=%b, want tx=%b busy=%b done=%b perr=0 ready=%b",
                 i, r_tx[i], r_busy[i], r_done[i], r_perr[i], r_rdy[i],
                 exp_line(8'hA5, 1'b1, i), (i < FL), (i == FL), (i >= FL));
      end
    end
  endtask

  task automatic test_parity_values;
    logic [DW-1:0] d;
    logic          p;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 8'hFF : 8'h01;
      p = (k == 0) ? 1'b1 : 1'b0;
      launch(d, p);
      capture(FL + 1);
      checks++;
      if (r_tx[(DW + 1) * CPB] !== p) begin
        errors++;
        $display("FAIL parity_bit data=%h got=%b want=%b", d, r_tx[(DW + 1) * CPB], p);
      end
      for (int i = 0; i < FL + 1; i++) begin
        checks++;
        if (r_tx[i] !== exp_line(d, p, i) || r_perr[i] !== 1'b0 || r_done[i] !== (i == FL)) begin
          errors++;
          $display("FAIL parity_values data=%h cyc=%0d tx=%b perr=%b done=%b, want tx=%b perr=0 done=%b",
                   d, i, r_tx[i], r_perr[i], r_done[i], exp_line(d, p, i), (i == FL));
        end
      end
    end
  endtask

  task automatic test_parity_mismatch;
    launch(8'h01, 1'b1);
    capture(FL + 1);
    for (int i = 0; i < FL + 1; i++) begin
      checks++;
      if (r_tx[i] !== exp_line(8'h01, 1'b1, i) || r_perr[i] !== (i == 0) ||
          r_done[i] !== (i == FL) || r_busy[i] !== (i < FL)) begin
        errors++;
        $display("FAIL parity_mismatch cyc=%0d tx=%b perr=%b done=%b busy=%b, want tx=%b perr=%b done=%b busy=%b",
                 i, r_tx[i], r_perr[i], r_done[i], r_busy[i],
                 exp_line(8'h01, 1'b1, i), (i == 0), (i == FL), (i < FL));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic exp_tx;
    @(negedge clk);
    bus.data_in   = 8'h3C;
    bus.parity_in = ~^8'h3C;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    // Swap to the second word while the first is in flight; it must not disturb frame one.
    bus.data_in   = 8'hC3;
    bus.parity_in = ~^8'hC3;
    for (int i = 0; i < 2 * FL + 3; i++) begin
      @(negedge clk);
      if (i == FL + 1) bus.in_valid = 1'b0;
      if (i < FL)           exp_tx = exp_line(8'h3C, ~^8'h3C, i);
      else if (i == FL)     exp_tx = 1'b1;
      else                  exp_tx = exp_line(8'hC3, ~^8'hC3, i - FL - 1);
      checks++;
      if (bus.tx_out !== exp_tx ||
          bus.frame_done !== (i == FL || i == 2 * FL + 1) ||
          bus.busy !== (i != FL && i <= 2 * FL) ||
          bus.parity_err !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d tx=%b done=%b busy=%b perr=%b, want tx=%b done=%b busy=%b perr=0",
                 i, bus.tx_out, bus.frame_done, bus.busy, bus.parity_err,
                 exp_tx, (i == FL || i == 2 * FL + 1), (i != FL && i <= 2 * FL));
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [DW-1:0] d;
    d = DW'($urandom);
    launch(d, ~^d);
    capture(4 * CPB + 1);
    checks++;
    if (r_tx[4 * CPB] !== d[3]) begin
      errors++;
      $display("FAIL mid_reset_bit3 got=%b want=%b", r_tx[4 * CPB], d[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort tx=%b busy=%b done=%b ready=%b, want 1 0 0 0",
               bus.tx_out, bus.busy, bus.frame_done, bus.in_ready);
    end
    rst = 1'b0;
    capture(FL + 4);
    for (int i = 0; i < FL + 4; i++) begin
      checks++;
      if (r_done[i] !== 1'b0 || r_tx[i] !== 1'b1 || r_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_quiet cyc=%0d done=%b tx=%b ready=%b, want 0 1 1",
                 i, r_done[i], r_tx[i], r_rdy[i]);
      end
    end
    launch(8'h55, 1'b1);
    capture(FL + 1);
    for (int i = 0; i < FL + 1; i++) begin
      checks++;
      if (r_tx[i] !== exp_line(8'h55, 1'b1, i) || r_done[i] !== (i == FL) || r_perr[i] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_refrm cyc=%0d tx=%b done=%b perr=%b, want tx=%b done=%b perr=0",
                 i, r_tx[i], r_done[i], r_perr[i], exp_line(8'h55, 1'b1, i), (i == FL));
      end
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] d;
    logic          p;
    logic          bad;
    for (int n = 0; n < 20; n++) begin
      d   = DW'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      p   = bad ? ^d : ~^d;
      launch(d, p);
      capture(FL + 1);
      for (int i = 0; i < FL + 1; i++) begin
        checks++;
        if (r_tx[i] !== exp_line(d, p, i) || r_perr[i] !== (i == 0 && bad) ||
            r_done[i] !== (i == FL) || r_busy[i] !== (i < FL)) begin
          errors++;
          $display("FAIL random n=%0d data=%h par=%b cyc=%0d tx=%b perr=%b done=%b busy=%b, want tx=%b perr=%b done=%b busy=%b",
                   n, d, p, i, r_tx[i], r_perr[i], r_done[i], r_busy[i],
                   exp_line(d, p, i), (i == 0 && bad), (i == FL), (i < FL));
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.data_in   = '0;
    bus.parity_in = 1'b0;
    bus.in_valid  = 1'b0;
    test_reset();
    test_single_frame();
    test_parity_values();
    test_parity_mismatch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
